// File: rtl/tsc_pkg.sv
// Shared lamp and phase encodings for the intersection phase scheduler.
// Lamp decode lives here so every consumer agrees on what each phase shows.
package tsc_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } lamp_e;

  typedef enum logic [2:0] {
    HG  = 3'd0,
    HY  = 3'd1,
    AR1 = 3'd2,
    CG  = 3'd3,
    CY  = 3'd4,
    AR2 = 3'd5
  } phase_e;

  // Returns {hwy, cntry}; undefined phase codes show both red.
  function automatic logic [3:0] phase_lamps(input phase_e ph);
    logic [3:0] l;
    l = {RED, RED};
    case (ph)
      HG:      l = {GREEN, RED};
      HY:      l = {YELLOW, RED};
      CG:      l = {RED, GREEN};
      CY:      l = {RED, YELLOW};
      default: l = {RED, RED};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tsc_phase_scheduler_if.sv
// Sensor/timebase inputs and lamp/status outputs of the phase scheduler.
// The master side drives the sensors and tick; the slave side is the scheduler.
interface tsc_phase_scheduler_if;
  logic       tick;
  logic       car_req;
  logic       ped_req;
  logic [1:0] hwy;
  logic [1:0] cntry;
  logic       ped_walk;
  logic       ped_pend;
  logic [2:0] phase;

  modport master (
    output tick, car_req, ped_req,
    input  hwy, cntry, ped_walk, ped_pend, phase
  );

  modport slave (
    input  tick, car_req, ped_req,
    output hwy, cntry, ped_walk, ped_pend, phase
  );
endinterface

// File: rtl/tsc_interval_timer.sv
// Tick counter for one phase interval: saturates at limit-1, done on the final tick.
// Restart clears it on a phase change; non-tick cycles hold the count.
module tsc_interval_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          tick,
  input  logic          restart,
  input  logic [TW-1:0] limit,
  output logic          done,
  output logic [TW-1:0] cnt
);

  logic [TW-1:0] last;

  assign last = limit - TW'(1);
  assign done = tick && (cnt == last);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (tick && (cnt != last)) begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

// File: rtl/tsc_phase_scheduler.sv
// Moore sequencer for the highway/country lights with a latched pedestrian request.
// Phase changes only on tick edges; all outputs come straight from registers.
module tsc_phase_scheduler
  import tsc_pkg::*;
#(
  parameter int Y2R_TK     = 3,
  parameter int R2G_TK     = 2,
  parameter int HWY_MIN_TK = 8,
  parameter int CTY_MAX_TK = 6,
  parameter int TW         = 4
) (
  input logic                   clk,
  input logic                   clear_n,
  tsc_phase_scheduler_if.slave  bus
);

  phase_e        state_q, state_d;
  logic          ped_q, walk_q;
  logic [TW-1:0] limit, t_cnt;
  logic          t_done, restart, enter_cg, exit_cg;

  always_comb begin
    limit = TW'(R2G_TK);
    case (state_q)
      HG:      limit = TW'(HWY_MIN_TK);
      HY, CY:  limit = TW'(Y2R_TK);
      CG:      limit = TW'(CTY_MAX_TK);
      default: limit = TW'(R2G_TK);
    endcase
  end

  tsc_interval_timer #(.TW(TW)) u_timer (
    .clk     (clk),
    .clear_n (clear_n),
    .tick    (bus.tick),
    .restart (restart),
    .limit   (limit),
    .done    (t_done),
    .cnt     (t_cnt)
  );

  always_ff @(posedge clk) begin
    if (!clear_n) state_q <= HG;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      // Highway green holds at its saturated count until someone asks to cross.
      HG:  if (bus.tick && (t_cnt == TW'(HWY_MIN_TK - 1)) && (bus.car_req || ped_q))
             state_d = HY;
      HY:  if (t_done) state_d = AR1;
      AR1: if (t_done) state_d = CG;
      // A walk in progress pins country green for the full interval.
      CG:  if (t_done || (bus.tick && !walk_q && !bus.car_req)) state_d = CY;
      CY:  if (t_done) state_d = AR2;
      AR2: if (t_done) state_d = HG;
      default: state_d = AR2;
    endcase
  end

  assign restart  = (state_d != state_q);
  assign enter_cg = (state_d == CG) && (state_q != CG);
  assign exit_cg  = (state_q == CG) && (state_d != CG);

  // A press on the CG-entry edge re-arms the latch for the following cycle.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      ped_q  <= 1'b0;
      walk_q <= 1'b0;
    end else if (enter_cg) begin
      walk_q <= ped_q;
      ped_q  <= bus.ped_req;
    end else begin
      ped_q <= ped_q | bus.ped_req;
      if (exit_cg) walk_q <= 1'b0;
    end
  end

  assign {bus.hwy, bus.cntry} = phase_lamps(state_q);
  assign bus.ped_walk         = walk_q;
  assign bus.ped_pend         = ped_q;
  assign bus.phase            = state_q;

endmodule

// File: tb/tb_tsc_phase_scheduler.sv
// Directed bench for the phase scheduler: per-cycle scoreboard against a reference
// model plus milestone checks on phase timing, pedestrian handling and reset.
module tb_tsc_phase_scheduler;
  import tsc_pkg::*;

  localparam int Y2R = 3, R2G = 2, HMIN = 8, CMAX = 6;

  typedef struct packed {
    logic [2:0] ph;
    logic [1:0] hwy;
    logic [1:0] cntry;
    logic       walk;
    logic       pend;
  } obs_t;

  logic clk = 1'b0;
  logic clear_n;
  tsc_phase_scheduler_if bus();

  tsc_phase_scheduler #(
    .Y2R_TK(Y2R), .R2G_TK(R2G), .HWY_MIN_TK(HMIN), .CTY_MAX_TK(CMAX), .TW(4)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   tick_no = 0;
  obs_t sb_q[$];

  int   m_ph, m_cnt;
  logic m_latch, m_walk;

  // Lamp pairs never both non-red, checked away from the active edge.
  always @(negedge clk) begin
    if (clear_n === 1'b1) begin
      n_tests++;
      assert (!((bus.hwy !== 2'd0) && (bus.cntry !== 2'd0))) else begin
        n_fail++;
        $error("FAIL lamp_conflict: hwy=%0d cntry=%0d, required one red", bus.hwy, bus.cntry);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  function automatic obs_t model_obs();
    obs_t o;
    o.ph   = 3'(m_ph);
    o.walk = m_walk;
    o.pend = m_latch;
    case (m_ph)
      0:       begin o.hwy = 2'd2; o.cntry = 2'd0; end
      1:       begin o.hwy = 2'd1; o.cntry = 2'd0; end
      3:       begin o.hwy = 2'd0; o.cntry = 2'd2; end
      4:       begin o.hwy = 2'd0; o.cntry = 2'd1; end
      default: begin o.hwy = 2'd0; o.cntry = 2'd0; end
    endcase
    return o;
  endfunction

  task automatic model_step();
    int nph, lim;
    if (!clear_n) begin
      m_ph = 0; m_cnt = 0; m_latch = 1'b0; m_walk = 1'b0;
    end else begin
      nph = m_ph;
      case (m_ph)
        0: if (bus.tick && m_cnt == HMIN - 1 && (bus.car_req || m_latch)) nph = 1;
        1: if (bus.tick && m_cnt == Y2R - 1) nph = 2;
        2: if (bus.tick && m_cnt == R2G - 1) nph = 3;
        3: if (bus.tick && (m_cnt == CMAX - 1 || (!m_walk && !bus.car_req))) nph = 4;
        4: if (bus.tick && m_cnt == Y2R - 1) nph = 5;
        default: if (bus.tick && m_cnt == R2G - 1) nph = 0;
      endcase
      if (nph == 3 && m_ph != 3) begin
        m_walk  = m_latch;
        m_latch = bus.ped_req;
      end else begin
        m_latch = m_latch | bus.ped_req;
        if (m_ph == 3 && nph != 3) m_walk = 1'b0;
      end
      case (m_ph)
        0:       lim = HMIN;
        1, 4:    lim = Y2R;
        3:       lim = CMAX;
        default: lim = R2G;
      endcase
      if (nph != m_ph) m_cnt = 0;
      else if (bus.tick && m_cnt < lim - 1) m_cnt++;
      m_ph = nph;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: push the model's prediction, then compare after the edge.
  task automatic cyc(input logic t);
    obs_t got, exp;
    bus.tick = t;
    model_step();
    sb_q.push_back(model_obs());
    @(posedge clk);
    #1;
    if (t) tick_no++;
    exp = sb_q.pop_front();
    got = {bus.phase, bus.hwy, bus.cntry, bus.ped_walk, bus.ped_pend};
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL sb@tick%0d: got ph=%0d hwy=%0d cty=%0d walk=%0d pend=%0d, expected ph=%0d hwy=%0d cty=%0d walk=%0d pend=%0d",
             tick_no, got.ph, got.hwy, got.cntry, got.walk, got.pend,
             exp.ph, exp.hwy, exp.cntry, exp.walk, exp.pend);
    end
    bus.tick = 1'b0;
  endtask

  task automatic do_tick();
    repeat (3) cyc(1'b0);
    cyc(1'b1);
  endtask

  task automatic run_ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic rst();
    clear_n = 1'b0;
    cyc(1'b0);
    clear_n = 1'b1;
    tick_no = 0;
  endtask

  function automatic int exp_car(input int n);
    if (n < 8)  return 0;
    if (n < 11) return 1;
    if (n < 13) return 2;
    if (n < 19) return 3;
    if (n < 22) return 4;
    if (n < 24) return 5;
    return 0;
  endfunction

  initial begin
    int bad;
    clear_n     = 1'b0;
    bus.tick    = 1'b0;
    bus.car_req = 1'b0;
    bus.ped_req = 1'b0;

    // Reset state
    rst();
    chk("rst_phase", bus.phase, 0);
    chk("rst_hwy", bus.hwy, 2);
    chk("rst_cntry", bus.cntry, 0);
    chk("rst_walk", bus.ped_walk, 0);
    chk("rst_pend", bus.ped_pend, 0);

    // Idle: no requests, highway stays green
    bad = 0;
    repeat (100) begin
      do_tick();
      if (bus.hwy !== 2'd2 || bus.cntry !== 2'd0) bad++;
    end
    chk("idle_lamps", bad, 0);

    // Car held: full cycle with country green capped at its maximum
    rst();
    bus.car_req = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      do_tick();
      chk($sformatf("car_ph_t%0d", n), bus.phase, exp_car(n));
    end
    bus.car_req = 1'b0;

    // Early release after two country-green ticks
    rst();
    bus.car_req = 1'b1;
    run_ticks(15);
    chk("early_in_cg", bus.phase, 3);
    bus.car_req = 1'b0;
    do_tick();
    chk("early_cy", bus.phase, 4);
    chk("early_nowalk", bus.ped_walk, 0);
    run_ticks(5);
    chk("early_back_hg", bus.phase, 0);

    // Pedestrian pulse on tick 3, no car
    rst();
    run_ticks(2);
    repeat (3) cyc(1'b0);
    bus.ped_req = 1'b1;
    cyc(1'b1);
    bus.ped_req = 1'b0;
    chk("ped_pend_now", bus.ped_pend, 1);
    chk("ped_still_hg", bus.phase, 0);
    run_ticks(4);
    chk("ped_hg_t7", bus.phase, 0);
    do_tick();
    chk("ped_hy_t8", bus.phase, 1);
    run_ticks(5);
    chk("ped_cg_t13", bus.phase, 3);
    chk("ped_walk_on", bus.ped_walk, 1);
    chk("ped_pend_clr", bus.ped_pend, 0);
    run_ticks(5);
    chk("ped_cg_t18", bus.phase, 3);
    chk("ped_walk_t18", bus.ped_walk, 1);
    do_tick();
    chk("ped_cy_t19", bus.phase, 4);
    chk("ped_walk_off", bus.ped_walk, 0);

    // Press on the CG-entry edge with the latch already set
    rst();
    bus.car_req = 1'b1;
    bus.ped_req = 1'b1;
    cyc(1'b0);
    bus.ped_req = 1'b0;
    run_ticks(12);
    chk("sim_ar1", bus.phase, 2);
    chk("sim_pend_pre", bus.ped_pend, 1);
    repeat (3) cyc(1'b0);
    bus.ped_req = 1'b1;
    cyc(1'b1);
    bus.ped_req = 1'b0;
    chk("sim_cg", bus.phase, 3);
    chk("sim_walk", bus.ped_walk, 1);
    chk("sim_pend_kept", bus.ped_pend, 1);
    cyc(1'b0);
    chk("sim_pend_next", bus.ped_pend, 1);

    // Reset mid country-green drops walk and latch
    clear_n = 1'b0;
    cyc(1'b0);
    clear_n = 1'b1;
    chk("midrst_phase", bus.phase, 0);
    chk("midrst_hwy", bus.hwy, 2);
    chk("midrst_walk", bus.ped_walk, 0);
    chk("midrst_pend", bus.ped_pend, 0);

    // No ticks for 50 cycles in highway yellow
    rst();
    bus.car_req = 1'b1;
    run_ticks(8);
    chk("frz_hy", bus.phase, 1);
    bad = 0;
    repeat (50) begin
      cyc(1'b0);
      if (bus.phase !== 3'd1 || bus.hwy !== 2'd1 || bus.cntry !== 2'd0) bad++;
    end
    chk("frz_held", bad, 0);
    run_ticks(2);
    chk("frz_hy_resume", bus.phase, 1);
    do_tick();
    chk("frz_ar1", bus.phase, 2);
    bus.car_req = 1'b0;

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
